// File: rtl/down_counter.sv
// ---------------------------------------------------------------------------
// down_counter
//   Loadable mod-MODULUS down counter with two personalities:
//     mode=0 : free-running wrap-around counter that emits a one-cycle borrow
//              pulse when it wraps from 0 back to MODULUS-1 (cascade stage).
//     mode=1 : one-shot countdown driven by a small IDLE/RUN/DONE FSM with a
//              start/busy/done handshake (timeout / delay generator).
//
// Parameters
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk       in   rising-edge system clock
//   reset     in   asynchronous active-low reset (0 = asserted)
//   en        in   count enable
//   load      in   synchronous load strobe, highest priority
//   load_val  in   value captured on load, clamped to MODULUS-1
//   mode      in   0 = free-run wrap, 1 = one-shot
//   start     in   one-shot start strobe, ignored in free-run mode
//   counter   out  registered current count
//   tc        out  terminal count, high while counter == 0
//   borrow    out  registered one-cycle pulse on the 0 -> MODULUS-1 wrap
//   busy      out  high while the one-shot FSM is in RUN
//   done      out  high while the one-shot FSM is in DONE
// ---------------------------------------------------------------------------
module down_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             start,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] counter_nxt;
  logic             borrow_nxt;
  logic [WIDTH-1:0] load_clamped;

  // Out-of-range load values saturate at the top of the count range so the
  // counter can never hold a value >= MODULUS.
  always_comb begin
    if ({1'b0, load_val} < MOD_EXT) begin
      load_clamped = load_val;
    end else begin
      load_clamped = MAX_VAL;
    end
  end

  // Next-state logic. Priority is load, then free-run counting, then the
  // one-shot FSM. Free-run mode parks the FSM in IDLE so a later switch to
  // one-shot always waits for a fresh start.
  always_comb begin
    counter_nxt = counter;
    state_nxt   = state;
    borrow_nxt  = 1'b0;

    if (load) begin
      counter_nxt = load_clamped;
      state_nxt   = IDLE;
    end else if (!mode) begin
      state_nxt = IDLE;
      if (en) begin
        if (counter == '0) begin
          counter_nxt = MAX_VAL;
          borrow_nxt  = 1'b1;
        end else begin
          counter_nxt = counter - WIDTH'(1);
        end
      end
    end else begin
      case (state)
        // The start edge only arms the FSM; the first decrement happens on
        // the following enabled edge.
        IDLE: begin
          if (start) begin
            state_nxt = RUN;
          end
        end
        // Reaching zero costs one more enabled edge before DONE, so done
        // rises N+1 edges after starting from N.
        RUN: begin
          if (en) begin
            if (counter != '0) begin
              counter_nxt = counter - WIDTH'(1);
            end else begin
              state_nxt = DONE;
            end
          end
        end
        // Restart from DONE reloads the full range.
        DONE: begin
          if (start) begin
            counter_nxt = MAX_VAL;
            state_nxt   = RUN;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= MAX_VAL;
      state   <= IDLE;
      borrow  <= 1'b0;
    end else begin
      counter <= counter_nxt;
      state   <= state_nxt;
      borrow  <= borrow_nxt;
    end
  end

  assign tc   = (counter == '0);
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
